// File: rtl/fas_freq_analyzer.sv
`default_nettype none
// ============================================================================
// Module      : fas_freq_analyzer
// Description : Peak-bin finder for one 16-point FFT frame. It captures the
//               frame on fft_valid and scans two bins per cycle, comparing
//               magnitude-squared values. It reports the index of the largest
//               bin on freq, together with a one-cycle done pulse, a busy
//               flag and a sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fas_freq_analyzer #(
    parameter int DW         = 16,
    parameter bit EXCLUDE_DC = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fft_valid,
    input  logic [2*DW-1:0] fft_d0,
    input  logic [2*DW-1:0] fft_d1,
    input  logic [2*DW-1:0] fft_d2,
    input  logic [2*DW-1:0] fft_d3,
    input  logic [2*DW-1:0] fft_d4,
    input  logic [2*DW-1:0] fft_d5,
    input  logic [2*DW-1:0] fft_d6,
    input  logic [2*DW-1:0] fft_d7,
    input  logic [2*DW-1:0] fft_d8,
    input  logic [2*DW-1:0] fft_d9,
    input  logic [2*DW-1:0] fft_d10,
    input  logic [2*DW-1:0] fft_d11,
    input  logic [2*DW-1:0] fft_d12,
    input  logic [2*DW-1:0] fft_d13,
    input  logic [2*DW-1:0] fft_d14,
    input  logic [2*DW-1:0] fft_d15,
    output logic            done,
    output logic [3:0]      freq,
    output logic            busy,
    output logic            overrun
);

    localparam int         c_NBINS = 16;
    localparam int         c_WW    = 2 * DW;   // packed {re, im} word width
    localparam int         c_MW    = 2 * DW;   // magnitude-squared width

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SCAN  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;

    logic [c_WW-1:0]   w_in  [c_NBINS];
    logic [c_WW-1:0]   r_buf [c_NBINS];

    logic [2:0]        r_cnt;
    logic [c_MW-1:0]   r_max;
    logic [3:0]        r_idx;
    logic              r_first;

    logic              w_capture;
    logic              w_drop;

    logic [3:0]        w_bin_e;
    logic [3:0]        w_bin_o;
    logic [c_WW-1:0]   w_word_e;
    logic [c_WW-1:0]   w_word_o;
    logic signed [DW-1:0]   w_re_e;
    logic signed [DW-1:0]   w_im_e;
    logic signed [DW-1:0]   w_re_o;
    logic signed [DW-1:0]   w_im_o;
    logic signed [c_MW-1:0] w_rr_e;
    logic signed [c_MW-1:0] w_ii_e;
    logic signed [c_MW-1:0] w_rr_o;
    logic signed [c_MW-1:0] w_ii_o;
    logic [c_MW-1:0]   w_m_e;
    logic [c_MW-1:0]   w_m_o;

    logic              w_cand_e;
    logic [c_MW-1:0]   w_max_mid;
    logic [3:0]        w_idx_mid;
    logic              w_first_mid;
    logic [c_MW-1:0]   w_max_nxt;
    logic [3:0]        w_idx_nxt;
    logic              w_first_nxt;

    assign w_in[0]  = fft_d0;
    assign w_in[1]  = fft_d1;
    assign w_in[2]  = fft_d2;
    assign w_in[3]  = fft_d3;
    assign w_in[4]  = fft_d4;
    assign w_in[5]  = fft_d5;
    assign w_in[6]  = fft_d6;
    assign w_in[7]  = fft_d7;
    assign w_in[8]  = fft_d8;
    assign w_in[9]  = fft_d9;
    assign w_in[10] = fft_d10;
    assign w_in[11] = fft_d11;
    assign w_in[12] = fft_d12;
    assign w_in[13] = fft_d13;
    assign w_in[14] = fft_d14;
    assign w_in[15] = fft_d15;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: a new frame may start from IDLE or straight out of DONE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (fft_valid) w_next_state = c_SCAN;
            c_SCAN:  if (r_cnt == 3'd7) w_next_state = c_DONE;
            c_DONE:  w_next_state = fft_valid ? c_SCAN : c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    // State-decoded controls: capture outside SCAN, drop inside SCAN
    always_comb begin
        busy      = (r_state == c_SCAN);
        w_capture = fft_valid && (r_state != c_SCAN);
        w_drop    = fft_valid && (r_state == c_SCAN);
    end

    // Magnitude-squared of the current bin pair (even bin 2c, odd bin 2c+1)
    always_comb begin
        w_bin_e  = {r_cnt, 1'b0};
        w_bin_o  = {r_cnt, 1'b1};
        w_word_e = r_buf[w_bin_e];
        w_word_o = r_buf[w_bin_o];
        w_re_e   = w_word_e[c_WW-1:DW];
        w_im_e   = w_word_e[DW-1:0];
        w_re_o   = w_word_o[c_WW-1:DW];
        w_im_o   = w_word_o[DW-1:0];
        w_rr_e   = w_re_e * w_re_e;
        w_ii_e   = w_im_e * w_im_e;
        w_rr_o   = w_re_o * w_re_o;
        w_ii_o   = w_im_o * w_im_o;
        // Each square is non-negative and at most 2^(2DW-2), so the
        // unsigned sum is at most 2^(2DW-1) and cannot overflow.
        w_m_e    = $unsigned(w_rr_e) + $unsigned(w_ii_e);
        w_m_o    = $unsigned(w_rr_o) + $unsigned(w_ii_o);
    end

    // Running-max update: even bin before odd bin, strict greater-than, so
    // the lower index wins ties. The first candidate always loads.
    always_comb begin
        w_cand_e    = !(EXCLUDE_DC && (r_cnt == 3'd0));
        w_max_mid   = r_max;
        w_idx_mid   = r_idx;
        w_first_mid = r_first;
        if (w_cand_e && (r_first || (w_m_e > r_max))) begin
            w_max_mid   = w_m_e;
            w_idx_mid   = w_bin_e;
            w_first_mid = 1'b0;
        end
        w_max_nxt   = w_max_mid;
        w_idx_nxt   = w_idx_mid;
        w_first_nxt = w_first_mid;
        if (w_first_mid || (w_m_o > w_max_mid)) begin
            w_max_nxt   = w_m_o;
            w_idx_nxt   = w_bin_o;
            w_first_nxt = 1'b0;
        end
    end

    // Frame buffer and scan datapath; the buffer changes only on capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < c_NBINS; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt   <= 3'd0;
            r_max   <= '0;
            r_idx   <= 4'd0;
            r_first <= 1'b0;
        end else if (w_capture) begin
            r_buf   <= w_in;
            r_cnt   <= 3'd0;
            r_max   <= '0;
            r_idx   <= 4'd0;
            r_first <= 1'b1;
        end else if (r_state == c_SCAN) begin
            r_cnt   <= r_cnt + 3'd1;
            r_max   <= w_max_nxt;
            r_idx   <= w_idx_nxt;
            r_first <= w_first_nxt;
        end
    end

    // Registered result: done pulses for one cycle and freq holds until the next frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done <= 1'b0;
            freq <= 4'd0;
        end else begin
            done <= (r_state == c_DONE);
            if (r_state == c_DONE) begin
                freq <= r_idx;
            end
        end
    end

    // Sticky overrun: set by any frame arriving while a scan is in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (w_drop) begin
            overrun <= 1'b1;
        end
    end

endmodule
`default_nettype wire
